// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Program-counter and fetch stage feeding the single-cycle riscv_cpu datapath.
//   A four-state FSM (FETCH -> RESP -> HOLD -> FETCH, or HOLD -> HALT) issues
//   one instruction-memory read per instruction. It captures the returned word
//   and holds it under a valid/ready handshake. On acceptance it advances the PC
//   to either pc+4 or the branch target pc+(imm<<1).
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset
//   address      out  instruction-memory word address, pc[ADDR_WIDTH+1:2]
//   mem_read     out  read strobe, high while in FETCH
//   mem_data     in   read data, valid the cycle after mem_read
//   instruction  out  held instruction word
//   pc           out  PC of the held or in-flight instruction
//   inst_valid   out  instruction is valid for the datapath (HOLD)
//   inst_ready   in   datapath accepts instruction this cycle
//   branch       in   branch control of the accepted instruction
//   zero         in   ALU zero flag of the accepted instruction
//   imm          in   immediate of the accepted instruction
//   misaligned   out  sticky: a computed next PC was not word aligned
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  mem_read,
  input  logic [63:0]           mem_data,
  output logic [63:0]           instruction,
  output logic [63:0]           pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  branch,
  input  logic                  zero,
  input  logic [63:0]           imm,
  output logic                  misaligned
);

  typedef enum logic [1:0] {FETCH, RESP, HOLD, HALT} state_t;

  state_t      state;
  logic [63:0] next_pc;

  // Next-PC arithmetic is plain modulo-2^64 addition. The immediate is treated
  // as signed and shifted left by one, so imm[63] falls off the top.
  function automatic logic [63:0] calc_next_pc(input logic [63:0] cur,
                                               input logic        take,
                                               input logic [63:0] off);
    logic signed [63:0] offset;
    offset = $signed(off) <<< 1;
    calc_next_pc = take ? (cur + offset) : (cur + 64'd4);
  endfunction

  // Address is a pure slice of the PC. It wraps silently past the end of the
  // instruction memory.
  assign address = pc[ADDR_WIDTH+1:2];

  always_comb begin
    next_pc = calc_next_pc(pc, branch & zero, imm);
  end

  // mem_read and inst_valid are registered alongside the state so that they
  // are pure decodes of the current state, independent of inst_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= 64'd0;
      inst_valid  <= 1'b0;
      mem_read    <= 1'b1;
      misaligned  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          state    <= RESP;
          mem_read <= 1'b0;
        end
        RESP: begin
          instruction <= mem_data;
          inst_valid  <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              pc       <= next_pc;
              mem_read <= 1'b1;
              state    <= FETCH;
            end else begin
              // Leave pc on the offending instruction so it can be inspected.
              misaligned <= 1'b1;
              state      <= HALT;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  address;
  logic        mem_read;
  logic [63:0] mem_data;
  logic [63:0] instruction;
  logic [63:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [63:0] imm = 64'd0;
  logic        misaligned;
  logic        dead_mode = 1'b0;

  logic        w_reset = 1'b1;
  logic [9:0]  w_address;
  logic        w_mem_read;
  logic [63:0] w_mem_data;
  logic [63:0] w_instruction;
  logic [63:0] w_pc;
  logic        w_inst_valid;
  logic        w_misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(64'd0), .ADDR_WIDTH(10)) u_dut (
    .clk(clk), .reset(reset), .address(address), .mem_read(mem_read),
    .mem_data(mem_data), .instruction(instruction), .pc(pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .branch(branch),
    .zero(zero), .imm(imm), .misaligned(misaligned)
  );

  instruction_fetch_unit #(.RESET_PC(64'd4092), .ADDR_WIDTH(10)) u_wrap (
    .clk(clk), .reset(w_reset), .address(w_address), .mem_read(w_mem_read),
    .mem_data(w_mem_data), .instruction(w_instruction), .pc(w_pc),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .branch(1'b0),
    .zero(1'b0), .imm(64'd0), .misaligned(w_misaligned)
  );

  // Instruction memory models: word k holds value k, data one cycle after read.
  always @(posedge clk) begin
    if (mem_read) mem_data <= dead_mode ? 64'hDEAD : {54'd0, address};
    if (w_mem_read) w_mem_data <= {54'd0, w_address};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (instruction !== 64'd0) begin errors++; $display("FAIL reset_instr: got %0h expected 0", instruction); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL reset_mem_read: got %b expected 1", mem_read); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    inst_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (mem_read !== 1'b1 || address !== 10'(k)) begin errors++; $display("FAIL seq_fetch%0d: mem_read=%b address=%0d expected 1/%0d", k, mem_read, address, k); end
      checks++; if (pc !== 64'(4 * k)) begin errors++; $display("FAIL seq_pc%0d: got %0d expected %0d", k, pc, 4 * k); end
      step();
      checks++; if (mem_read !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL seq_resp%0d: mem_read=%b valid=%b expected 0/0", k, mem_read, inst_valid); end
      step();
      checks++; if (inst_valid !== 1'b1 || instruction !== 64'(k)) begin errors++; $display("FAIL seq_hold%0d: valid=%b instr=%0h expected 1/%0h", k, inst_valid, instruction, k); end
      step();
    end
  endtask

  task automatic test_stall();
    checks++; if (address !== 10'd2 || pc !== 64'd8) begin errors++; $display("FAIL stall_start: address=%0d pc=%0d expected 2/8", address, pc); end
    inst_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid !== 1'b1 || instruction !== 64'd2 || pc !== 64'd8 || mem_read !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: valid=%b instr=%0h pc=%0d mem_read=%b expected 1/2/8/0", i, inst_valid, instruction, pc, mem_read); end
      step();
    end
    inst_ready = 1'b1;
    step();
    checks++; if (pc !== 64'd12 || mem_read !== 1'b1 || address !== 10'd3 || inst_valid !== 1'b0) begin errors++; $display("FAIL stall_release: pc=%0d mem_read=%b address=%0d valid=%b expected 12/1/3/0", pc, mem_read, address, inst_valid); end
  endtask

  task automatic test_branch();
    step(); step(); step();
    checks++; if (pc !== 64'd16) begin errors++; $display("FAIL branch_setup: got pc=%0d expected 16", pc); end
    branch = 1'b1; zero = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FFF8;
    step(); step();
    checks++; if (instruction !== 64'd4 || inst_valid !== 1'b1) begin errors++; $display("FAIL branch_hold: instr=%0h valid=%b expected 4/1", instruction, inst_valid); end
    step();
    checks++; if (pc !== 64'd0 || address !== 10'd0 || mem_read !== 1'b1) begin errors++; $display("FAIL branch_taken: pc=%0h address=%0d mem_read=%b expected 0/0/1", pc, address, mem_read); end
    zero = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); step(); step(); end
    checks++; if (pc !== 64'd16) begin errors++; $display("FAIL branch_nt_setup: got pc=%0d expected 16", pc); end
    step(); step(); step();
    checks++; if (pc !== 64'd20 || address !== 10'd5) begin errors++; $display("FAIL branch_not_taken: pc=%0d address=%0d expected 20/5", pc, address); end
    branch = 1'b0; imm = 64'd0;
  endtask

  task automatic test_misaligned();
    apply_reset();
    branch = 1'b1; zero = 1'b1; imm = 64'd1;
    step(); step(); step();
    checks++; if (misaligned !== 1'b1 || pc !== 64'd0) begin errors++; $display("FAIL mis_flag: misaligned=%b pc=%0h expected 1/0", misaligned, pc); end
    checks++; if (inst_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL mis_halt: valid=%b mem_read=%b expected 0/0", inst_valid, mem_read); end
    branch = 1'b0; zero = 1'b0; imm = 64'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (mem_read !== 1'b0 || inst_valid !== 1'b0 || misaligned !== 1'b1) begin errors++; $display("FAIL mis_stay%0d: mem_read=%b valid=%b misaligned=%b expected 0/0/1", i, mem_read, inst_valid, misaligned); end
    end
    apply_reset();
    checks++; if (misaligned !== 1'b0 || mem_read !== 1'b1 || address !== 10'd0) begin errors++; $display("FAIL mis_reset: misaligned=%b mem_read=%b address=%0d expected 0/1/0", misaligned, mem_read, address); end
    step(); step(); step();
    checks++; if (pc !== 64'd4) begin errors++; $display("FAIL mis_resume: got pc=%0d expected 4", pc); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dead_mode = 1'b1;
    step();
    checks++; if (mem_data !== 64'hDEAD) begin errors++; $display("FAIL mid_setup: mem_data=%0h expected dead", mem_data); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    dead_mode = 1'b0;
    checks++; if (instruction !== 64'd0 || inst_valid !== 1'b0 || mem_read !== 1'b1 || pc !== 64'd0) begin errors++; $display("FAIL mid_reset: instr=%0h valid=%b mem_read=%b pc=%0h expected 0/0/1/0", instruction, inst_valid, mem_read, pc); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (inst_valid === 1'b1 && instruction === 64'hDEAD) begin errors++; $display("FAIL mid_dead%0d: instr=%0h valid=%b expected not dead", i, instruction, inst_valid); end
    end
  endtask

  task automatic test_wrap();
    w_reset = 1'b1;
    step();
    w_reset = 1'b0;
    checks++; if (w_address !== 10'd1023 || w_pc !== 64'd4092 || w_mem_read !== 1'b1) begin errors++; $display("FAIL wrap_start: address=%0d pc=%0d mem_read=%b expected 1023/4092/1", w_address, w_pc, w_mem_read); end
    step(); step();
    checks++; if (w_instruction !== 64'd1023 || w_inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_hold: instr=%0d valid=%b expected 1023/1", w_instruction, w_inst_valid); end
    step();
    checks++; if (w_pc !== 64'd4096 || w_address !== 10'd0 || w_misaligned !== 1'b0 || w_mem_read !== 1'b1) begin errors++; $display("FAIL wrap_next: pc=%0d address=%0d misaligned=%b mem_read=%b expected 4096/0/0/1", w_pc, w_address, w_misaligned, w_mem_read); end
    step(); step();
    checks++; if (w_instruction !== 64'd0 || w_inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_word0: instr=%0d valid=%b expected 0/1", w_instruction, w_inst_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misaligned();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
